// File: rtl/sea_byte_loader.sv
// sea_byte_loader: byte-serial loader/unloader around the 96-bit SEA core.
// Collects 18 input bytes into li/ri/ki, pulses core_start, waits
// CORE_LATENCY cycles, captures {lio,rio} and streams it back out as 12 bytes.
module sea_byte_loader #(
  parameter int CORE_LATENCY = 92
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [47:0] li,
  output logic [47:0] ri,
  output logic [47:0] ki,
  output logic        core_start,
  input  logic [47:0] lio,
  input  logic [47:0] rio,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam int LW = $clog2(CORE_LATENCY + 1);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_UNLOAD} state_t;

  state_t        r_state, w_nxt;
  logic [4:0]    r_cnt;
  logic [LW-1:0] r_lat;
  logic          r_pend;    // start pulse owed to the core (first RUN cycle)
  logic [95:0]   r_res;
  logic          r_busy;
  logic          w_in_xfer, w_out_xfer, w_cap;

  // Handshake decodes; in_ready is forced low while reset is held.
  assign in_ready   = ena && rst_n && (r_state == S_LOAD);
  assign out_valid  = ena && (r_state == S_UNLOAD);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;
  assign w_cap      = ena && (r_state == S_RUN) && !r_pend && (r_lat == LW'(1));

  // A pending start is held across ena=0 and emitted once ena returns.
  assign core_start = ena && r_pend && (r_state == S_RUN);
  assign out_data   = r_res[95:88];
  assign busy       = r_busy;

  // State register; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_state <= S_LOAD;
    else if (ena) r_state <= w_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_LOAD:   if (w_in_xfer && r_cnt == 5'd17)  w_nxt = S_RUN;
      S_RUN:    if (w_cap)                        w_nxt = S_UNLOAD;
      S_UNLOAD: if (w_out_xfer && r_cnt == 5'd11) w_nxt = S_LOAD;
      default:                                    w_nxt = S_LOAD;
    endcase
  end

  // Datapath: byte assembly, latency countdown, result capture and shift-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_lat  <= '0;
      r_pend <= 1'b0;
      r_res  <= '0;
      r_busy <= 1'b0;
      li     <= '0;
      ri     <= '0;
      ki     <= '0;
    end else if (ena) begin
      r_busy <= (w_nxt != S_LOAD);
      case (r_state)
        S_LOAD: if (w_in_xfer) begin
          // MSB-first: shifting left places byte 0 of each field on top.
          if (r_cnt < 5'd6)       li <= {li[39:0], in_data};
          else if (r_cnt < 5'd12) ri <= {ri[39:0], in_data};
          else                    ki <= {ki[39:0], in_data};
          if (r_cnt == 5'd17) begin
            r_cnt  <= '0;
            r_pend <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_RUN: begin
          if (r_pend) begin
            r_pend <= 1'b0;
            r_lat  <= LW'(CORE_LATENCY);
          end else if (r_lat == LW'(1)) begin
            r_res <= {lio, rio};
          end else begin
            r_lat <= r_lat - LW'(1);
          end
        end
        S_UNLOAD: if (w_out_xfer) begin
          r_res <= {r_res[87:0], 8'h00};
          r_cnt <= (r_cnt == 5'd11) ? 5'd0 : r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
